sram_port_arbiter: RTL and testbench

//  Shares the single off-chip 16-bit SRAM port between instruction fetch (IF) and the MEM stage.

---
 rtl/thinpad_mem_pkg.sv | 27 ++
 rtl/sram_access_seq.sv | 102 ++++++++++
 rtl/sram_port_arbiter.sv | 107 ++++++++++
 tb/tb_sram_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/thinpad_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : thinpad_mem_pkg
//  Description : Shared definitions for the SRAM port arbiter: access
//                sequencer state encodings, port-owner encoding and the
//                default board SRAM address width.
//  Revision    : 1.0  initial release
// ============================================================================
package thinpad_mem_pkg;

  localparam int SRAM_ADDR_W = 18;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4
  } seq_state_t;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/sram_access_seq.sv
`default_nettype none
// ============================================================================
//  Module      : sram_access_seq
//  Description : Timing sequencer for one SRAM access. Holds the access FSM,
//                the registered SRAM strobes, address, write data and the
//                read-data capture register.
//  Ports       : clk, rst             clock, synchronous active-high reset
//                start, start_wr      begin an access (write when start_wr=1)
//                addr, wdata          access word address / store data
//                busy                 FSM is not IDLE
//                done                 one-cycle completion pulse (in IDLE)
//                rdata                last captured read data
//                sram_*               board SRAM pins
//  Revision    : 1.0  initial release
// ============================================================================
module sram_access_seq
  import thinpad_mem_pkg::*;
#(
  parameter int READ_WAIT = 1,
  parameter int WR_PULSE  = 1,
  parameter int ADDR_W    = SRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              start_wr,
  input  logic [15:0]       addr,
  input  logic [15:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [15:0]       rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dout,
  output logic              sram_doe,
  input  logic [15:0]       sram_din,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam logic [2:0] RD_LAST = 3'(READ_WAIT - 1);
  localparam logic [2:0] WR_LAST = 3'(WR_PULSE - 1);

  seq_state_t state;
  seq_state_t state_nxt;
  logic [2:0] cnt;
  logic       rd_end;

  always_comb begin
    state_nxt = state;
    rd_end    = 1'b0;
    case (state)
      ST_IDLE:     if (start) state_nxt = start_wr ? ST_WR_SETUP : ST_RD;
      ST_RD: begin
        if (cnt == RD_LAST) begin
          state_nxt = ST_IDLE;
          rd_end    = 1'b1;
        end
      end
      ST_WR_SETUP: state_nxt = ST_WR_PULSE;
      ST_WR_PULSE: if (cnt == WR_LAST) state_nxt = ST_WR_HOLD;
      ST_WR_HOLD:  state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // Strobes are registered from the next state so that they change on the
  // same edge as the FSM; oe_n and doe belong to disjoint states and so can
  // never be active together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 3'd0;
      done      <= 1'b0;
      rdata     <= 16'h0000;
      sram_addr <= '0;
      sram_dout <= 16'h0000;
      sram_doe  <= 1'b0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= (state_nxt != state || state == ST_IDLE) ? 3'd0 : cnt + 3'd1;
      done      <= rd_end | (state == ST_WR_HOLD);
      sram_ce_n <= (state_nxt == ST_IDLE);
      sram_oe_n <= (state_nxt != ST_RD);
      sram_we_n <= (state_nxt != ST_WR_PULSE);
      sram_doe  <= (state_nxt == ST_WR_SETUP) || (state_nxt == ST_WR_PULSE) ||
                   (state_nxt == ST_WR_HOLD);
      if (state == ST_IDLE && start) begin
        sram_addr <= {{(ADDR_W-16){1'b0}}, addr};
        sram_dout <= wdata;
      end
      if (rd_end) rdata <= sram_din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_port_arbiter
//  Description : Shares the single 16-bit board SRAM port between the
//                instruction-fetch (IF) and MEM stages. Grants in IDLE only,
//                priority mem_wr > mem_rd > if_req; the owner is latched at
//                grant. mem_conflict tells the front-end to stall IF.
//  Ports       : clk, rst                       clock, sync active-high reset
//                if_req/if_addr/if_rdata/if_valid   fetch interface
//                mem_rd/mem_wr/mem_addr/mem_wdata/mem_rdata/mem_valid
//                                               load/store interface
//                mem_conflict                   IF stall (combinational)
//                sram_addr/dout/doe/din/ce_n/oe_n/we_n   SRAM pins
//                conflict_cnt                   saturating count of conflict
//                                               cycles (only when the macro
//                                               ARB_CONFLICT_CNT_EN is defined)
//  Revision    : 1.0  initial release
// ============================================================================
module sram_port_arbiter
  import thinpad_mem_pkg::*;
#(
  parameter int READ_WAIT = 1,
  parameter int WR_PULSE  = 1,
  parameter int ADDR_W    = SRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [15:0]       if_addr,
  output logic [15:0]       if_rdata,
  output logic              if_valid,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [15:0]       mem_addr,
  input  logic [15:0]       mem_wdata,
  output logic [15:0]       mem_rdata,
  output logic              mem_valid,
  output logic              mem_conflict,
`ifdef ARB_CONFLICT_CNT_EN
  output logic [15:0]       conflict_cnt,
`endif
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dout,
  output logic              sram_doe,
  input  logic [15:0]       sram_din,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  logic        busy;
  logic        done;
  logic        start;
  logic        mem_any;
  logic [15:0] acc_addr;
  logic [15:0] rdata;
  owner_t      owner;

  assign mem_any  = mem_rd | mem_wr;
  assign start    = !busy && (mem_any || if_req);
  assign acc_addr = mem_any ? mem_addr : if_addr;

  // Owner only changes on a grant, so it still names the finished access in
  // the completion cycle even if a new grant is made in that same cycle.
  always_ff @(posedge clk) begin
    if (rst)        owner <= OWNER_IF;
    else if (start) owner <= mem_any ? OWNER_MEM : OWNER_IF;
  end

  assign if_valid     = done && (owner == OWNER_IF);
  assign mem_valid    = done && (owner == OWNER_MEM);
  assign if_rdata     = rdata;
  assign mem_rdata    = rdata;
  assign mem_conflict = if_req && (mem_any || (busy && owner == OWNER_MEM));

`ifdef ARB_CONFLICT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                      conflict_cnt <= 16'h0000;
    else if (mem_conflict && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'h0001;
  end
`endif

  sram_access_seq #(
    .READ_WAIT (READ_WAIT),
    .WR_PULSE  (WR_PULSE),
    .ADDR_W    (ADDR_W)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_wr  (mem_wr),
    .addr      (acc_addr),
    .wdata     (mem_wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .sram_addr (sram_addr),
    .sram_dout (sram_dout),
    .sram_doe  (sram_doe),
    .sram_din  (sram_din),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n)
  );

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_port_arbiter
//  Description : Self-checking bench for sram_port_arbiter with a small
//                behavioural SRAM model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_valid;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  logic        mem_conflict;
  logic [17:0] sram_addr;
  logic [15:0] sram_dout;
  logic        sram_doe;
  logic [15:0] sram_din;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
`ifdef ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  sram_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_rdata     (if_rdata),
    .if_valid     (if_valid),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_valid    (mem_valid),
    .mem_conflict (mem_conflict),
`ifdef ARB_CONFLICT_CNT_EN
    .conflict_cnt (conflict_cnt),
`endif
    .sram_addr    (sram_addr),
    .sram_dout    (sram_dout),
    .sram_doe     (sram_doe),
    .sram_din     (sram_din),
    .sram_ce_n    (sram_ce_n),
    .sram_oe_n    (sram_oe_n),
    .sram_we_n    (sram_we_n)
  );

  // Behavioural SRAM: asynchronous read while selected and output-enabled,
  // write on any clock edge where we_n is low and the pad is driven.
  logic [15:0] sram [0:255];
  assign sram_din = (!sram_ce_n && !sram_oe_n) ? sram[sram_addr[7:0]] : 16'h0000;
  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n && sram_doe) sram[sram_addr[7:0]] <= sram_dout;

  always @(negedge clk)
    if (!sram_oe_n && sram_doe) overlap++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; mem_rd = 0; mem_wr = 0; mem_addr = 0; mem_wdata = 0;
  endtask

  typedef struct {
    logic        if_req;
    logic [15:0] if_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        e_ifv;
    logic        e_memv;
    logic        e_conf;
    logic        chk_conf;
    logic        e_ce;
    logic        e_oe;
    logic        e_we;
    logic        e_doe;
    logic        chk_data;
    logic [15:0] e_data;
    logic [17:0] e_addr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
      input logic ir, input logic [15:0] ia, input logic mr, input logic mw,
      input logic [15:0] ma, input logic [15:0] mwd,
      input logic ifv, input logic memv, input logic conf, input logic chkc,
      input logic ce, input logic oe, input logic we, input logic doe,
      input logic chkd, input logic [15:0] d, input logic [17:0] a);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.mem_rd = mr; v.mem_wr = mw;
    v.mem_addr = ma; v.mem_wdata = mwd;
    v.e_ifv = ifv; v.e_memv = memv; v.e_conf = conf; v.chk_conf = chkc;
    v.e_ce = ce; v.e_oe = oe; v.e_we = we; v.e_doe = doe;
    v.chk_data = chkd; v.e_data = d; v.e_addr = a;
    return v;
  endfunction

  int cyc;
  logic seen;

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = 16'h0000;
    sram[4] = 16'h4915;

    //                ir ia       rd wr ma       wd        ifv mv cf cc ce oe we doe cd data      addr
    // Fetch only
    tbl.push_back(mk(1, 16'h0004, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 1, 1, 0, 0, 16'h0000, 18'h0));
    tbl.push_back(mk(1, 16'h0004, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 0, 1, 0, 0, 16'h0000, 18'h4));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 1, 1, 1, 1, 0, 1, 16'h4915, 18'h0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 1, 1, 0, 0, 16'h0000, 18'h0));
    // Store BEEF at 0x10
    tbl.push_back(mk(0, 16'h0000, 0, 1, 16'h0010, 16'hBEEF, 0, 0, 0, 1, 1, 1, 1, 0, 0, 16'h0000, 18'h0));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 16'h0010, 16'hBEEF, 0, 0, 0, 1, 0, 1, 1, 1, 0, 16'h0000, 18'h10));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 16'h0010, 16'hBEEF, 0, 0, 0, 1, 0, 1, 0, 1, 0, 16'h0000, 18'h10));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 16'h0010, 16'hBEEF, 0, 0, 0, 1, 0, 1, 1, 1, 0, 16'h0000, 18'h10));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 1, 1, 1, 1, 0, 0, 16'h0000, 18'h0));
    // Simultaneous fetch and load: MEM first, then IF
    tbl.push_back(mk(1, 16'h0004, 1, 0, 16'h0010, 16'h0000, 0, 0, 1, 1, 1, 1, 1, 0, 0, 16'h0000, 18'h0));
    tbl.push_back(mk(1, 16'h0004, 1, 0, 16'h0010, 16'h0000, 0, 0, 1, 1, 0, 0, 1, 0, 0, 16'h0000, 18'h10));
    tbl.push_back(mk(1, 16'h0004, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 1, 1, 1, 1, 0, 1, 16'hBEEF, 18'h0));
    tbl.push_back(mk(1, 16'h0004, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 0, 1, 0, 0, 16'h0000, 18'h4));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 1, 1, 1, 1, 0, 1, 16'h4915, 18'h0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 1, 1, 0, 0, 16'h0000, 18'h0));
    // Load raised during an in-flight fetch: fetch finishes first
    tbl.push_back(mk(1, 16'h0004, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 1, 1, 0, 0, 16'h0000, 18'h0));
    tbl.push_back(mk(1, 16'h0004, 1, 0, 16'h0010, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 18'h4));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 16'h0010, 16'h0000, 1, 0, 0, 1, 1, 1, 1, 0, 1, 16'h4915, 18'h0));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 16'h0010, 16'h0000, 0, 0, 0, 1, 0, 0, 1, 0, 0, 16'h0000, 18'h10));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 1, 1, 1, 1, 0, 1, 16'hBEEF, 18'h0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 1, 1, 0, 0, 16'h0000, 18'h0));

    // Reset state
    idle_inputs();
    rst = 1;
    step();
    step();
    chk("rst_ce_n", sram_ce_n, 1);
    chk("rst_oe_n", sram_oe_n, 1);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_doe", sram_doe, 0);
    chk("rst_valids", {if_valid, mem_valid}, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_rdata", {if_rdata, mem_rdata}, 0);
    rst = 0;

    foreach (tbl[k]) begin
      if_req = tbl[k].if_req; if_addr = tbl[k].if_addr;
      mem_rd = tbl[k].mem_rd; mem_wr = tbl[k].mem_wr;
      mem_addr = tbl[k].mem_addr; mem_wdata = tbl[k].mem_wdata;
      @(negedge clk);
      chk($sformatf("row%0d_if_valid", k), if_valid, tbl[k].e_ifv);
      chk($sformatf("row%0d_mem_valid", k), mem_valid, tbl[k].e_memv);
      if (tbl[k].chk_conf) chk($sformatf("row%0d_conflict", k), mem_conflict, tbl[k].e_conf);
      chk($sformatf("row%0d_ce_n", k), sram_ce_n, tbl[k].e_ce);
      chk($sformatf("row%0d_oe_n", k), sram_oe_n, tbl[k].e_oe);
      chk($sformatf("row%0d_we_n", k), sram_we_n, tbl[k].e_we);
      chk($sformatf("row%0d_doe", k), sram_doe, tbl[k].e_doe);
      if (!tbl[k].e_ce) chk($sformatf("row%0d_addr", k), sram_addr, tbl[k].e_addr);
      if (tbl[k].chk_data) begin
        if (tbl[k].e_ifv)  chk($sformatf("row%0d_if_rdata", k), if_rdata, tbl[k].e_data);
        if (tbl[k].e_memv) chk($sformatf("row%0d_mem_rdata", k), mem_rdata, tbl[k].e_data);
      end
      step();
    end
    chk("sram_0x10", sram[16], 16'hBEEF);

    // Write and read together: write wins, dout drives wdata, latency 4
    if_req = 1; if_addr = 16'h0004; mem_rd = 1; mem_wr = 1;
    mem_addr = 16'h0030; mem_wdata = 16'hA5A5;
    @(negedge clk);
    chk("prio_conflict", mem_conflict, 1);
    step();
    chk("prio_doe", sram_doe, 1);
    chk("prio_oe_n", sram_oe_n, 1);
    chk("prio_dout", sram_dout, 16'hA5A5);
    cyc = 1;
    seen = 0;
    while (!seen && cyc < 12) begin
      if (mem_valid) seen = 1;
      else begin step(); cyc++; end
    end
    chk("prio_wr_latency", cyc, 4);
    chk("prio_if_valid", if_valid, 0);
    mem_rd = 0; mem_wr = 0; if_req = 0;
    step();
    chk("sram_0x30", sram[48], 16'hA5A5);

    // Reset during the write pulse aborts the access
    mem_wr = 1; mem_addr = 16'h0020; mem_wdata = 16'h1234;
    step();
    step();
    chk("abort_in_pulse_we_n", sram_we_n, 0);
    rst = 1;
    step();
    chk("abort_we_n", sram_we_n, 1);
    chk("abort_ce_n", sram_ce_n, 1);
    chk("abort_doe", sram_doe, 0);
    chk("abort_mem_valid", mem_valid, 0);
    rst = 0; mem_wr = 0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (mem_valid || !sram_ce_n) seen = 1;
    end
    chk("abort_stays_idle", seen, 0);

`ifdef ARB_CONFLICT_CNT_EN
    rst = 1;
    step();
    rst = 0;
    chk("cnt_reset", conflict_cnt, 16'h0000);
    if_req = 1; mem_rd = 1; mem_addr = 16'h0010;
    for (int i = 0; i < 5; i++) step();
    chk("cnt_five", conflict_cnt, 16'd5);
    for (int i = 5; i < 16'hFFFE; i++) step();
    chk("cnt_fffe", conflict_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) step();
    chk("cnt_saturate", conflict_cnt, 16'hFFFF);
    idle_inputs();
    step();
`endif

    chk("oe_doe_overlap", overlap, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
